// File: rtl/line_rotator_pkg.sv
// Shared types and constants for the BT.656 line rotator.
// rot_addr maps an output index to the stored-line read address.
package line_rotator_pkg;

  localparam int SAMPLE_W  = 10;
  localparam int BUF_DEPTH = 2048;
  localparam int ADDR_W    = 11;
  localparam int CUT_SCALE = 4;
  localparam int EAV_GUARD = 4;
  localparam int LEN_W     = ADDR_W + 1;

  typedef logic [SAMPLE_W-1:0]      sample_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [LEN_W-1:0]         len_t;
  typedef logic signed [ADDR_W+2:0] sw_t;

  typedef struct packed {
    len_t  line_len;
    addr_t active_start;
    len_t  offset;
  } line_cfg_t;

  // Rotate only inside [active_start, line_len-EAV_GUARD).
  function automatic addr_t rot_addr(addr_t k, line_cfg_t c);
    sw_t   kk;
    sw_t   st;
    sw_t   ln;
    sw_t   off;
    sw_t   lim;
    sw_t   alen;
    sw_t   rel;
    addr_t a;
    kk  = $signed({3'b000, k});
    st  = $signed({3'b000, c.active_start});
    ln  = $signed({2'b00, c.line_len});
    off = $signed({2'b00, c.offset});
    lim  = ln - sw_t'(EAV_GUARD);
    alen = lim - st;
    if (alen <= sw_t'(0) || off >= alen)
      off = sw_t'(0);
    rel = kk - st + off;
    if (rel >= alen)
      rel = rel - alen;
    a = k;
    if (kk >= st && kk < lim)
      a = addr_t'(st + rel);
    return a;
  endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Ping-pong line store: 2 x 2048 x 10 simple dual-port RAM.
// Writes go to wr_bank, reads come from the other bank, 1-cycle read.
module line_buffer_2bank
  import line_rotator_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    wr_bank,
  input  addr_t   wr_addr,
  input  sample_t wr_data,
  input  addr_t   rd_addr,
  output sample_t rd_data
);

  sample_t mem [0:2*BUF_DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset_n)
      mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      rd_data <= '0;
    else
      rd_data <= mem[{~wr_bank, rd_addr}];
  end

endmodule

// File: rtl/line_rotator.sv
// BT.656 line scrambler: each line is replayed one line late, rotated.
// Define LINE_ROTATOR_VBLANK_ROTATE_EN to rotate during V blanking too.
module line_rotator
  import line_rotator_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic [7:0]          raw_cut_position,
  input  logic                V,
  input  logic                H,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                data_valid
);

  logic      prev_h;
  logic      bank;
  logic      seen_rise;
  addr_t     write_index;
  addr_t     sav_index;
  line_cfg_t cfg;
  logic      h_rise;
  logic      h_fall;
  len_t      cut_off;
  len_t      next_off;
  addr_t     rd_addr;

  assign h_rise  = H && !prev_h;
  assign h_fall  = !H && prev_h;
  assign cut_off = len_t'(raw_cut_position) * len_t'(CUT_SCALE);

`ifdef LINE_ROTATOR_VBLANK_ROTATE_EN
  assign next_off = cut_off;
`else
  assign next_off = V ? '0 : cut_off;
`endif

  assign rd_addr = rot_addr(write_index, cfg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_h      <= 1'b0;
      bank        <= 1'b0;
      seen_rise   <= 1'b0;
      data_valid  <= 1'b0;
      write_index <= '0;
      sav_index   <= '0;
      cfg         <= '0;
    end else begin
      prev_h <= H;
      if (h_fall)
        sav_index <= write_index;
      if (h_rise) begin
        bank             <= ~bank;
        write_index      <= '0;
        cfg.line_len     <= len_t'(write_index) + len_t'(1);
        cfg.active_start <= sav_index;
        cfg.offset       <= next_off;
        seen_rise        <= 1'b1;
        if (seen_rise)
          data_valid <= 1'b1;
      end else if (write_index != addr_t'(BUF_DEPTH-1)) begin
        // Overlong lines pile up on the last slot instead of wrapping.
        write_index <= write_index + addr_t'(1);
      end
    end
  end

  line_buffer_2bank u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_bank (bank),
    .wr_addr (write_index),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_line_rotator.sv
// Scoreboard bench for line_rotator: line-level reference model
// plus directed checks at hand-derived rotation points.
module tb_line_rotator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] data_in;
  logic [7:0] cut;
  logic       V;
  logic       H;
  logic [9:0] data_out;
  logic       data_valid;

  always #5 clk = ~clk;

  line_rotator dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .raw_cut_position (cut),
    .V                (V),
    .H                (H),
    .data_out         (data_out),
    .data_valid       (data_valid)
  );

  typedef struct {
    logic [9:0] dout;
    logic       valid;
    bit         chk;
    logic [9:0] dexp;
    bit         dchk;
    string      tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [9:0] mm    [2][2048];
  bit         known [2][2048];
  logic [9:0] hist  [9][2048];
  bit m_prev_h = 0;
  bit m_bank   = 0;
  bit m_valid  = 0;
  int m_widx   = 0;
  int m_sav    = 0;
  int m_len    = 0;
  int m_start  = 0;
  int m_off    = 0;
  int m_rises  = 0;

  function automatic int ref_addr(int k);
    int alen;
    int off;
    alen = m_len - 4 - m_start;
    off  = m_off;
    if (alen <= 0 || off >= alen) off = 0;
    if (k < m_start || k >= m_len - 4) return k;
    return m_start + ((k - m_start + off) % alen);
  endfunction

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    total++;
    assert (data_valid === e.valid) else begin
      bad++;
      $error("FAIL %s data_valid got=%0b want=%0b", e.tag, data_valid, e.valid);
    end
    if (e.chk) begin
      total++;
      assert (data_out === e.dout) else begin
        bad++;
        $error("FAIL %s data_out got=%h want=%h", e.tag, data_out, e.dout);
      end
    end
    if (e.dchk) begin
      total++;
      assert (data_out === e.dexp) else begin
        bad++;
        $error("FAIL %s directed data_out got=%h want=%h", e.tag, data_out, e.dexp);
      end
    end
  endtask

  task automatic cycle(bit rst, bit h, bit v, logic [7:0] c,
                       logic [9:0] d, int line, int k);
    exp_t e;
    int   a;
    int   rb;
    @(negedge clk);
    check_out();
    reset_n = !rst;
    H       = h;
    V       = v;
    cut     = c;
    data_in = d;
    e.tag  = "stream";
    e.dchk = 0;
    e.dexp = '0;
    if (rst) begin
      m_prev_h = 0; m_bank = 0; m_valid = 0; m_widx = 0; m_sav = 0;
      m_len = 0; m_start = 0; m_off = 0; m_rises = 0;
      e.tag  = "reset";
      e.dout = '0;
      e.chk  = 1;
    end else begin
      rb = m_bank ? 0 : 1;
      a  = ref_addr(m_widx);
      e.dout = mm[rb][a];
      e.chk  = m_valid && known[rb][a];
      mm[m_bank][m_widx]    = d;
      known[m_bank][m_widx] = 1;
      hist[line][(k > 2047) ? 2047 : k] = d;
      if (!h && m_prev_h) m_sav = m_widx;
      if (h && !m_prev_h) begin
        m_len   = m_widx + 1;
        m_start = m_sav;
`ifdef LINE_ROTATOR_VBLANK_ROTATE_EN
        m_off = int'(c) * 4;
`else
        m_off = v ? 0 : int'(c) * 4;
`endif
        m_bank = !m_bank;
        m_widx = 0;
        m_rises++;
        if (m_rises >= 2) m_valid = 1;
      end else if (m_widx < 2047) begin
        m_widx++;
      end
      m_prev_h = h;
      if (line == 2 && k == 10) begin
        e.dchk = 1; e.dexp = hist[1][10]; e.tag = "identity";
      end
      if (line == 3 && k == 276) begin
        e.dchk = 1; e.dexp = hist[2][788]; e.tag = "rot_start";
      end
      if (line == 3 && k == 1200) begin
        e.dchk = 1; e.dexp = hist[2][276]; e.tag = "rot_wrap";
      end
      if (line == 3 && k == 100) begin
        e.dchk = 1; e.dexp = hist[2][100]; e.tag = "rot_pass_lo";
      end
      if (line == 3 && k == 1713) begin
        e.dchk = 1; e.dexp = hist[2][1713]; e.tag = "rot_pass_hi";
      end
      if (line == 4 && k == 276) begin
        e.dchk = 1; e.tag = "vblank";
`ifdef LINE_ROTATOR_VBLANK_ROTATE_EN
        e.dexp = hist[3][1076];
`else
        e.dexp = hist[3][276];
`endif
      end
      if (line == 5 && k == 500) begin
        e.dchk = 1; e.dexp = hist[4][1520]; e.tag = "cut255_mid";
      end
      if (line == 5 && k == 700) begin
        e.dchk = 1; e.dexp = hist[4][284]; e.tag = "cut255_wrap";
      end
      if (line == 6 && k == 40) begin
        e.dchk = 1; e.dexp = hist[5][40]; e.tag = "long_line_lo";
      end
      if (line == 6 && k == 1715) begin
        e.dchk = 1; e.dexp = hist[5][1715]; e.tag = "long_line_hi";
      end
    end
    e.valid = m_valid;
    q.push_back(e);
  endtask

  task automatic run_line(int line, int len, logic [7:0] c, bit v, bit pre);
    bit h;
    for (int k = 0; k < len; k++) begin
      h = pre ? (k == len - 1) : (k < 276 || k == len - 1);
      cycle(0, h, v, c, 10'($urandom), line, k);
    end
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++)
      cycle(1, 0, 0, 8'd0, 10'($urandom), 8, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    H       = 1'b0;
    V       = 1'b0;
    cut     = 8'd0;
    data_in = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 2048; i++)
        known[b][i] = 0;

    do_reset(3);
    run_line(0, 101, 8'd0, 0, 1);
    run_line(1, 1716, 8'd0, 0, 0);
    run_line(2, 1716, 8'd128, 0, 0);
    run_line(3, 1716, 8'd200, 1, 0);
    run_line(4, 1716, 8'd255, 0, 0);
    run_line(5, 2100, 8'd0, 0, 0);
    run_line(6, 1716, 8'd0, 0, 0);
    run_line(7, 1716, 8'd0, 0, 0);
    run_line(8, 500, 8'd0, 0, 0);

    do_reset(3);
    run_line(0, 101, 8'd0, 0, 1);
    run_line(1, 1716, 8'd0, 0, 0);
    run_line(2, 1716, 8'd0, 0, 0);

    @(negedge clk);
    check_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
